// File: rtl/fp16_pkg.sv
// fp16_pkg: shared fp16 constants and ReLU helpers
package fp16_pkg;

    localparam logic [15:0] FP16_ZERO      = 16'h0000;
    localparam logic [15:0] FP16_EXP_MASK  = 16'h7C00;
    localparam logic [15:0] FP16_MANT_MASK = 16'h03FF;

    function automatic logic fp16_is_nan(input logic [15:0] x);
        return ((x & FP16_EXP_MASK) == FP16_EXP_MASK) && ((x & FP16_MANT_MASK) != FP16_ZERO);
    endfunction

    // Negative values and NaNs clamp to +0; +inf and every other value pass through
    function automatic logic [15:0] fp16_relu(input logic [15:0] x);
        return (x[15] || fp16_is_nan(x)) ? FP16_ZERO : x;
    endfunction

endpackage

// File: rtl/fp16_max2.sv
// fp16_max2: max of two non-negative fp16 magnitudes, ties keep operand a
module fp16_max2 (
    input  logic [14:0] a_i,
    input  logic [14:0] b_i,
    output logic [14:0] max_o
);

    assign max_o = (b_i > a_i) ? b_i : a_i;

endmodule

// File: rtl/relu_maxpool_fp16.sv
// relu_maxpool_fp16: ReLU followed by 2x2/stride-2 max pooling over a raster fp16 stream
module relu_maxpool_fp16
    import fp16_pkg::*;
#(
    parameter int ROW_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_eol
);

    localparam int CW = $clog2(ROW_W);
    localparam int IW = (ROW_W > 2) ? $clog2(ROW_W / 2) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROW_W - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic          row_odd_q, row_odd_d, cur_row;
    logic [14:0]   hold_q, hold_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_eol_q, out_eol_d;
    logic [14:0]   lb_q [ROW_W/2];
    logic [14:0]   word, hmax, pmax;
    logic [IW-1:0] idx;
    logic          is_odd, is_last, done;

    // sof forces the word to row 0 col 0, which also discards any partial window
    assign word    = 15'(fp16_relu(in_data));
    assign cur_col = in_sof ? '0 : col_q;
    assign cur_row = in_sof ? 1'b0 : row_odd_q;
    assign is_odd  = cur_col[0];
    assign is_last = cur_col == LAST;
    assign idx     = IW'(cur_col >> 1);
    assign done    = is_odd & cur_row;

    fp16_max2 u_hmax (.a_i(hold_q),    .b_i(word), .max_o(hmax));
    fp16_max2 u_pmax (.a_i(lb_q[idx]), .b_i(hmax), .max_o(pmax));

    // Advance raster position, capture the even-column word and form the pooled result
    always_comb begin
        col_d       = col_q;
        row_odd_d   = row_odd_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_eol_d   = 1'b0;
        if (in_valid) begin
            col_d       = is_last ? '0 : cur_col + 1'b1;
            row_odd_d   = cur_row ^ is_last;
            hold_d      = is_odd ? hold_q : word;
            out_valid_d = done;
            out_eol_d   = done & is_last;
            out_data_d  = done ? {1'b0, pmax} : out_data_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_odd_q   <= 1'b0;
            hold_q      <= '0;
            out_data_q  <= FP16_ZERO;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_odd_q   <= row_odd_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_eol_q   <= out_eol_d;
        end
    end

    // Even rows park horizontal maxima; every entry is rewritten before an odd row reads it
    always_ff @(posedge clk) begin
        if (in_valid && is_odd && !cur_row) lb_q[idx] <= hmax;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_eol   = out_eol_q;

endmodule
